// File: rtl/efc_tck_pkg.sv
// Shared encodings for the efuse JTAG TCK-domain sequencer: instructions,
// FSM states, status-word bit positions and default widths.
package efc_tck_pkg;

  localparam int DW_DEF   = 32;
  localparam int CNTW_DEF = 6;

  localparam logic [1:0] INSTR_NONE   = 2'b00;
  localparam logic [1:0] INSTR_READ   = 2'b01;
  localparam logic [1:0] INSTR_PROG   = 2'b10;
  localparam logic [1:0] INSTR_STATUS = 2'b11;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    SHIFT      = 2'b01,
    PEND       = 2'b10,
    PEND_SHIFT = 2'b11
  } efc_state_e;

  localparam int ST_BIT_PEND = 31;
  localparam int ST_BIT_LEN  = 30;
  localparam int ST_BIT_OVR  = 29;
  localparam int ST_BIT_TMO  = 28;

  // READ and PROG are the only instructions that turn a scan into a command.
  function automatic logic is_cmd_instr(input logic [1:0] instr);
    return (instr == INSTR_READ) || (instr == INSTR_PROG);
  endfunction

endpackage

// File: rtl/efc_tck_ctl_if.sv
// Command handshake between the TCK sequencer (master) and the efuse engine
// (slave).
interface efc_tck_ctl_if
  import efc_tck_pkg::*;
#(
  parameter int DW = DW_DEF
) ();

  logic          cmd_vld;
  logic          cmd_op;
  logic [DW-1:0] cmd_data;
  logic          cmd_ack;
  logic          efc_busy;

  modport master (output cmd_vld, output cmd_op, output cmd_data, output efc_busy, input cmd_ack);
  modport slave  (input cmd_vld, input cmd_op, input cmd_data, input efc_busy, output cmd_ack);

endinterface

// File: rtl/efc_tck_bitcnt.sv
// Saturating shift-bit counter with synchronous clear and count enable.
module efc_tck_bitcnt #(
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  output logic [CNTW-1:0] cnt
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  // Count strobes, holding at the top value so long scans still read as too long.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CNTW{1'b0}};
    end else if (clr) begin
      cnt <= {CNTW{1'b0}};
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/efc_tck_ctl.sv
// TCK-domain sequencer for the efuse JTAG data register: gates CTU strobes,
// muxes the status word and issues READ/PROG commands. Optional command
// timeout is enabled by defining EFC_TCK_CTL_TMO_EN.
module efc_tck_ctl
  import efc_tck_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int CNTW    = CNTW_DEF,
  parameter int TMO_CYC = 1024
) (
  input  logic              tck,
  input  logic              tck_rst,
  input  logic [1:0]        ctu_efc_instr,
  input  logic              ctu_efc_capturedr,
  input  logic              ctu_efc_shiftdr,
  input  logic              ctu_efc_updatedr,
  input  logic [DW-1:0]     tck_shft_data_ff,
  output logic              efc_capturedr,
  output logic              efc_shiftdr,
  output logic [DW-1:0]     efc_cap_data,
  efc_tck_ctl_if.master     cmd_if
);

  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DW);

  efc_state_e      state_r;
  logic            cmd_vld_r;
  logic            cmd_op_r;
  logic [DW-1:0]   cmd_data_r;
  logic            len_err_r;
  logic            ovr_err_r;
  logic            tmo_err_r;
  logic [CNTW-1:0] last_cnt_r;

  logic            cap_s;
  logic            shift_s;
  logic            upd_s;
  logic            cmd_instr_s;
  logic            full_s;
  logic            pend_s;
  logic            ack_vld_s;
  logic            tmo_hit_s;
  logic            retire_s;
  logic            rd_clr_s;
  logic            cnt_clr_s;
  logic            cnt_en_s;
  logic [CNTW-1:0] cnt_s;
  logic [DW-1:0]   status_s;

  assign cap_s       = ctu_efc_capturedr & (ctu_efc_instr != INSTR_NONE);
  assign shift_s     = ctu_efc_shiftdr & (ctu_efc_instr != INSTR_NONE);
  assign upd_s       = ctu_efc_updatedr;
  assign cmd_instr_s = is_cmd_instr(ctu_efc_instr);
  assign full_s      = (cnt_s == FULL_CNT);
  assign pend_s      = (state_r == PEND) || (state_r == PEND_SHIFT);
  assign ack_vld_s   = cmd_if.cmd_ack & cmd_vld_r;
  assign retire_s    = ack_vld_s | tmo_hit_s;
  assign rd_clr_s    = cap_s & (ctu_efc_instr == INSTR_STATUS);
  // A capture coinciding with update is dropped, so it must not restart the count.
  assign cnt_clr_s   = cap_s & ~upd_s;
  assign cnt_en_s    = shift_s & ((state_r == SHIFT) || (state_r == PEND_SHIFT));

  assign efc_capturedr   = cap_s;
  assign efc_shiftdr     = shift_s;
  assign cmd_if.cmd_vld  = cmd_vld_r;
  assign cmd_if.cmd_op   = cmd_op_r;
  assign cmd_if.cmd_data = cmd_data_r;
  assign cmd_if.efc_busy = cmd_vld_r;

  efc_tck_bitcnt #(.CNTW(CNTW)) u_bitcnt (
    .clk (tck),
    .rst (tck_rst),
    .clr (cnt_clr_s),
    .en  (cnt_en_s),
    .cnt (cnt_s)
  );

`ifdef EFC_TCK_CTL_TMO_EN
  localparam int TW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  logic [TW-1:0] tmo_cnt_r;

  assign tmo_hit_s = pend_s & ~ack_vld_s & (tmo_cnt_r == TW'(TMO_CYC - 1));

  // Cycles spent waiting for the engine since the command was posted.
  always_ff @(posedge tck) begin
    if (tck_rst) begin
      tmo_cnt_r <= {TW{1'b0}};
    end else if (!pend_s || ack_vld_s || tmo_hit_s) begin
      tmo_cnt_r <= {TW{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Status word seen by a STATUS capture; other instructions load fuse data elsewhere.
  always_comb begin
    status_s              = {DW{1'b0}};
    status_s[ST_BIT_PEND] = pend_s;
    status_s[ST_BIT_LEN]  = len_err_r;
    status_s[ST_BIT_OVR]  = ovr_err_r;
    status_s[ST_BIT_TMO]  = tmo_err_r;
    status_s[CNTW-1:0]    = last_cnt_r;
    if (ctu_efc_instr == INSTR_STATUS) begin
      efc_cap_data = status_s;
    end else begin
      efc_cap_data = {DW{1'b0}};
    end
  end

  // Sequencer FSM; error clears come first so a same-cycle error set overrides them.
  always_ff @(posedge tck) begin
    if (tck_rst) begin
      state_r    <= IDLE;
      cmd_vld_r  <= 1'b0;
      cmd_op_r   <= 1'b0;
      cmd_data_r <= {DW{1'b0}};
      len_err_r  <= 1'b0;
      ovr_err_r  <= 1'b0;
      tmo_err_r  <= 1'b0;
      last_cnt_r <= {CNTW{1'b0}};
    end else begin
      if (rd_clr_s) begin
        len_err_r <= 1'b0;
        ovr_err_r <= 1'b0;
        tmo_err_r <= 1'b0;
      end
      if (tmo_hit_s) begin
        tmo_err_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          state_r <= (cap_s && !upd_s) ? SHIFT : IDLE;
        end
        SHIFT: begin
          if (upd_s) begin
            last_cnt_r <= cnt_s;
            if (cmd_instr_s && full_s) begin
              cmd_data_r <= tck_shft_data_ff;
              cmd_op_r   <= ctu_efc_instr[1];
              cmd_vld_r  <= 1'b1;
              state_r    <= PEND;
            end else begin
              len_err_r <= len_err_r | cmd_instr_s;
              state_r   <= IDLE;
            end
          end else begin
            state_r <= SHIFT;
          end
        end
        PEND: begin
          if (retire_s) begin
            cmd_vld_r <= 1'b0;
            state_r   <= (cap_s && !upd_s) ? SHIFT : IDLE;
          end else begin
            state_r <= (cap_s && !upd_s) ? PEND_SHIFT : PEND;
          end
        end
        PEND_SHIFT: begin
          if (retire_s) begin
            // The retiring command frees the slot, so the scan is judged as a fresh one.
            cmd_vld_r <= 1'b0;
            if (upd_s) begin
              last_cnt_r <= cnt_s;
              if (cmd_instr_s && full_s) begin
                cmd_data_r <= tck_shft_data_ff;
                cmd_op_r   <= ctu_efc_instr[1];
                cmd_vld_r  <= 1'b1;
                state_r    <= PEND;
              end else begin
                len_err_r <= len_err_r | cmd_instr_s;
                state_r   <= IDLE;
              end
            end else begin
              state_r <= SHIFT;
            end
          end else if (upd_s) begin
            last_cnt_r <= cnt_s;
            ovr_err_r  <= ovr_err_r | (cmd_instr_s & full_s);
            state_r    <= PEND;
          end else begin
            state_r <= PEND_SHIFT;
          end
        end
        default: begin
          cmd_vld_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_efc_tck_ctl.sv
// Directed self-checking bench for efc_tck_ctl; the timeout scenario runs
// only when EFC_TCK_CTL_TMO_EN is defined (TMO_CYC = 8 here).
module tb_efc_tck_ctl;
  import efc_tck_pkg::*;

  logic        tck;
  logic        tck_rst;
  logic [1:0]  ctu_efc_instr;
  logic        ctu_efc_capturedr;
  logic        ctu_efc_shiftdr;
  logic        ctu_efc_updatedr;
  logic [31:0] tck_shft_data_ff;
  logic        efc_capturedr;
  logic        efc_shiftdr;
  logic [31:0] efc_cap_data;
  logic [31:0] st_w;

  int n_chk  = 0;
  int n_pass = 0;

  efc_tck_ctl_if #(.DW(32)) cmd_if ();

  efc_tck_ctl #(.DW(32), .CNTW(6), .TMO_CYC(8)) dut (
    .tck               (tck),
    .tck_rst           (tck_rst),
    .ctu_efc_instr     (ctu_efc_instr),
    .ctu_efc_capturedr (ctu_efc_capturedr),
    .ctu_efc_shiftdr   (ctu_efc_shiftdr),
    .ctu_efc_updatedr  (ctu_efc_updatedr),
    .tck_shft_data_ff  (tck_shft_data_ff),
    .efc_capturedr     (efc_capturedr),
    .efc_shiftdr       (efc_shiftdr),
    .efc_cap_data      (efc_cap_data),
    .cmd_if            (cmd_if)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  task automatic scan(input logic [1:0] ins, input int nbits, input logic [31:0] word, input logic ack_at_upd);
    ctu_efc_instr     = ins;
    ctu_efc_capturedr = 1'b1;
    step();
    ctu_efc_capturedr = 1'b0;
    ctu_efc_shiftdr   = 1'b1;
    repeat (nbits) step();
    ctu_efc_shiftdr   = 1'b0;
    tck_shft_data_ff  = word;
    ctu_efc_updatedr  = 1'b1;
    cmd_if.cmd_ack    = ack_at_upd;
    step();
    ctu_efc_updatedr  = 1'b0;
    cmd_if.cmd_ack    = 1'b0;
  endtask

  task automatic rd_status(output logic [31:0] w);
    ctu_efc_instr     = INSTR_STATUS;
    ctu_efc_capturedr = 1'b1;
    #1;
    w = efc_cap_data;
    step();
    ctu_efc_capturedr = 1'b0;
  endtask

  initial begin
    tck_rst = 1'b1;
    ctu_efc_instr = 2'b00;
    ctu_efc_capturedr = 1'b0;
    ctu_efc_shiftdr = 1'b0;
    ctu_efc_updatedr = 1'b0;
    tck_shft_data_ff = 32'h0;
    cmd_if.cmd_ack = 1'b0;
    step();
    step();
    tck_rst = 1'b0;
    step();

    chk("rst_vld", {31'd0, cmd_if.cmd_vld}, 32'd0);
    chk("rst_op", {31'd0, cmd_if.cmd_op}, 32'd0);
    chk("rst_data", cmd_if.cmd_data, 32'h0);
    chk("rst_busy", {31'd0, cmd_if.efc_busy}, 32'd0);
    chk("cap_data_none", efc_cap_data, 32'h0);

    // Instruction 00 freezes the datapath
    ctu_efc_capturedr = 1'b1;
    ctu_efc_shiftdr   = 1'b1;
    #1;
    chk("gate_cap_none", {31'd0, efc_capturedr}, 32'd0);
    chk("gate_shift_none", {31'd0, efc_shiftdr}, 32'd0);
    repeat (4) step();
    ctu_efc_instr = INSTR_READ;
    #1;
    chk("gate_cap_read", {31'd0, efc_capturedr}, 32'd1);
    chk("gate_shift_read", {31'd0, efc_shiftdr}, 32'd1);
    ctu_efc_capturedr = 1'b0;
    ctu_efc_shiftdr   = 1'b0;
    ctu_efc_instr     = INSTR_NONE;
    rd_status(st_w);
    chk("st_after_none", st_w, 32'h0000_0000);

    // READ command with ack three cycles later
    scan(INSTR_READ, 32, 32'h0000_0A5C, 1'b0);
    chk("rd_vld", {31'd0, cmd_if.cmd_vld}, 32'd1);
    chk("rd_op", {31'd0, cmd_if.cmd_op}, 32'd0);
    chk("rd_data", cmd_if.cmd_data, 32'h0000_0A5C);
    chk("rd_busy", {31'd0, cmd_if.efc_busy}, 32'd1);
    repeat (3) step();
    chk("rd_hold_vld", {31'd0, cmd_if.cmd_vld}, 32'd1);
    cmd_if.cmd_ack = 1'b1;
    step();
    cmd_if.cmd_ack = 1'b0;
    chk("rd_ack_vld", {31'd0, cmd_if.cmd_vld}, 32'd0);
    chk("rd_ack_busy", {31'd0, cmd_if.efc_busy}, 32'd0);

    // Short PROG scan reports a length error, cleared by the first read
    scan(INSTR_PROG, 31, 32'hDEAD_BEEF, 1'b0);
    chk("len_no_vld", {31'd0, cmd_if.cmd_vld}, 32'd0);
    rd_status(st_w);
    chk("len_st1", st_w, 32'h4000_001F);
    rd_status(st_w);
    chk("len_st2", st_w, 32'h0000_001F);

`ifndef EFC_TCK_CTL_TMO_EN
    // Second full scan while a PROG is pending is an overrun
    scan(INSTR_PROG, 32, 32'h1234_5678, 1'b0);
    chk("pg_vld", {31'd0, cmd_if.cmd_vld}, 32'd1);
    chk("pg_op", {31'd0, cmd_if.cmd_op}, 32'd1);
    chk("pg_data", cmd_if.cmd_data, 32'h1234_5678);
    scan(INSTR_PROG, 32, 32'hCAFE_F00D, 1'b0);
    chk("ovr_data", cmd_if.cmd_data, 32'h1234_5678);
    chk("ovr_vld", {31'd0, cmd_if.cmd_vld}, 32'd1);
    rd_status(st_w);
    chk("ovr_st", st_w, 32'hA000_0020);

    // Ack and update together in PEND_SHIFT: old retires, new issues
    scan(INSTR_READ, 32, 32'h0000_BEEF, 1'b1);
    chk("au_vld", {31'd0, cmd_if.cmd_vld}, 32'd1);
    chk("au_op", {31'd0, cmd_if.cmd_op}, 32'd0);
    chk("au_data", cmd_if.cmd_data, 32'h0000_BEEF);
    cmd_if.cmd_ack = 1'b1;
    step();
    cmd_if.cmd_ack = 1'b0;
    chk("au_ret_vld", {31'd0, cmd_if.cmd_vld}, 32'd0);
    rd_status(st_w);
    chk("au_st", st_w, 32'h0000_0020);

    // Stray ack with nothing pending has no effect
    cmd_if.cmd_ack = 1'b1;
    step();
    cmd_if.cmd_ack = 1'b0;
    chk("stray_ack_vld", {31'd0, cmd_if.cmd_vld}, 32'd0);

    // Without timeout, a command waits indefinitely
    scan(INSTR_READ, 32, 32'h0000_55AA, 1'b0);
    repeat (20) step();
    chk("nt_hold_vld", {31'd0, cmd_if.cmd_vld}, 32'd1);
    rd_status(st_w);
    chk("nt_st", st_w, 32'h8000_0020);
    cmd_if.cmd_ack = 1'b1;
    step();
    cmd_if.cmd_ack = 1'b0;
    chk("nt_ack_vld", {31'd0, cmd_if.cmd_vld}, 32'd0);
`else
    // Timeout abandons the command after 8 pending cycles
    scan(INSTR_READ, 32, 32'h0000_55AA, 1'b0);
    chk("tmo_vld0", {31'd0, cmd_if.cmd_vld}, 32'd1);
    repeat (7) step();
    chk("tmo_vld7", {31'd0, cmd_if.cmd_vld}, 32'd1);
    step();
    chk("tmo_vld8", {31'd0, cmd_if.cmd_vld}, 32'd0);
    rd_status(st_w);
    chk("tmo_st", st_w, 32'h1000_0020);
`endif

    // Reset in the middle of a pending command
    scan(INSTR_PROG, 32, 32'h0F0F_0F0F, 1'b0);
    chk("mid_vld", {31'd0, cmd_if.cmd_vld}, 32'd1);
    tck_rst = 1'b1;
    step();
    tck_rst = 1'b0;
    chk("mid_rst_vld", {31'd0, cmd_if.cmd_vld}, 32'd0);
    chk("mid_rst_data", cmd_if.cmd_data, 32'h0);
    rd_status(st_w);
    chk("mid_rst_st", st_w, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
